// File: rtl/bank_access_ctrl.sv
// bank_access_ctrl: client-side controller for the multi-bank memory.
// Buffers writes in a small FIFO and issues at most one read and one write per cycle.
// A queued write yields to a read on the same sub-memory until it has been blocked
// STARVE_MAX times in a row; after that, reads stall for one cycle so the write can go.
// Reads stall while any queued write targets the same address, so read data is never stale.
// Read data comes back two edges after the read is accepted.
module bank_access_ctrl #(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WQ_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rsp_valid,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(WQ_DEPTH):0]   wq_level,
    output logic                        mem_ren,
    output logic [ADDR_W-1:0]           mem_raddr,
    output logic                        mem_wen,
    output logic [ADDR_W-1:0]           mem_waddr,
    output logic [DATA_W-1:0]           mem_din,
    input  logic [DATA_W-1:0]           mem_dout
);

    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(WQ_DEPTH);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

    // Write queue storage; q_vld marks live entries for the read-after-write hazard check.
    logic [ADDR_W-1:0]   q_addr [WQ_DEPTH];
    logic [DATA_W-1:0]   q_data [WQ_DEPTH];
    logic [WQ_DEPTH-1:0] q_vld;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LVL_W-1:0]    level;
    logic [STV_W-1:0]    stv;

    logic                pend_valid;
    logic [ADDR_W-1:0]   pend_addr;

    logic                nonempty;
    logic                hazard;
    logic                force_w;
    logic                conflict;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    assign wq_level = level;

    // Hazard: the requested read address matches any live queue entry.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Issue logic: read goes first, head write goes unless it collides on the sub-memory.
    always_comb begin
        nonempty  = (level != '0);
        force_w   = (stv == STV_MAX);
        wr_ready  = !rst && (level != FULL_LVL);
        rd_ready  = !rst && !hazard && !force_w;
        mem_ren   = rd_valid && rd_ready;
        mem_raddr = rd_addr;
        head_addr = '0;
        head_data = '0;
        if (nonempty) begin
            head_addr = q_addr[rd_ptr];
            head_data = q_data[rd_ptr];
        end
        mem_waddr = head_addr;
        mem_din   = head_data;
        conflict  = mem_ren && (rd_addr[ADDR_W-1:7] == head_addr[ADDR_W-1:7]);
        mem_wen   = !rst && nonempty && !conflict;
        push      = wr_valid && wr_ready;
        pop       = mem_wen;
    end

    // Queue pointers, level and valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            q_vld  <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + PTR_W'(1);
                q_vld[wr_ptr]  <= 1'b1;
            end
            if (pop) begin
                rd_ptr         <= rd_ptr + PTR_W'(1);
                q_vld[rd_ptr]  <= 1'b0;
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Queue payload; contents need no reset because q_vld qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= wr_addr;
            q_data[wr_ptr] <= wr_data;
        end
    end

    // Starvation counter: counts consecutive edges the head write lost to a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            stv <= '0;
        end else if (mem_wen) begin
            stv <= '0;
        end else if (nonempty && conflict && (stv != STV_MAX)) begin
            stv <= stv + STV_W'(1);
        end
    end

    // Response pipe: capture the address at accept, pair it with mem_dout one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            rsp_valid  <= 1'b0;
            rsp_addr   <= '0;
            rsp_data   <= '0;
        end else begin
            pend_valid <= mem_ren;
            if (mem_ren) begin
                pend_addr <= rd_addr;
            end
            rsp_valid <= pend_valid;
            if (pend_valid) begin
                rsp_addr <= pend_addr;
                rsp_data <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_bank_access_ctrl.sv
// Bench for bank_access_ctrl: memory stub, queue-based reference model, directed + random stimulus.
module tb_bank_access_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [2:0]    wq_level;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 clk = ~clk;

    bank_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .wq_level  (wq_level),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    function automatic logic [7:0] init_val(input int a);
        if (a == 'h200) return 8'h11;
        if (a == 'h201) return 8'h22;
        if (a == 'h202) return 8'h33;
        return 8'((a & 'hFF) ^ 'h3C);
    endfunction

    // Memory stub: registered read; a write colliding with a read on one sub-memory is lost.
    logic [7:0] mem [2048];
    always @(posedge clk) begin
        if (mem_ren) mem_dout <= mem[mem_raddr];
        if (mem_wen && !(mem_ren && (mem_raddr[10:7] == mem_waddr[10:7])))
            mem[mem_waddr] <= mem_din;
    end

    // Reference model state.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t           q[$];
    int            stv;
    logic [7:0]    ref_mem [2048];
    bit            pend_v;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    bit            m_rsp_v;
    logic [AW-1:0] m_rsp_a;
    logic [DW-1:0] m_rsp_d;
    bit            just_reset;
    bit            e_wr_ready;
    bit            e_ren;
    bit            e_wen;

    int n_cmp;
    int n_bad;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Apply inputs at the falling edge and compare every output against the model.
    task automatic drive(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit rv, input logic [AW-1:0] ra);
        bit            hz;
        bit            e_rd_ready;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd; rd_valid = rv; rd_addr = ra;
        #1;
        hz = 1'b0;
        foreach (q[i]) if (q[i].a == ra) hz = 1'b1;
        e_wr_ready = !r && (q.size() < DEPTH);
        e_rd_ready = !r && !hz && (stv != SMAX);
        e_ren      = rv && e_rd_ready;
        e_wa = '0;
        e_wd = '0;
        if (q.size() > 0) begin
            e_wa = q[0].a;
            e_wd = q[0].d;
        end
        e_wen = !r && (q.size() > 0) && !(e_ren && ((ra >> 7) == (e_wa >> 7)));
        chk("wr_ready",  32'(wr_ready),  32'(e_wr_ready));
        chk("rd_ready",  32'(rd_ready),  32'(e_rd_ready));
        chk("mem_ren",   32'(mem_ren),   32'(e_ren));
        chk("mem_raddr", 32'(mem_raddr), 32'(ra));
        chk("mem_wen",   32'(mem_wen),   32'(e_wen));
        chk("mem_waddr", 32'(mem_waddr), 32'(e_wa));
        chk("mem_din",   32'(mem_din),   32'(e_wd));
        chk("wq_level",  32'(wq_level),  32'(q.size()));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
        if (m_rsp_v || just_reset) begin
            chk("rsp_addr", 32'(rsp_addr), 32'(m_rsp_a));
            chk("rsp_data", 32'(rsp_data), 32'(m_rsp_d));
        end
    endtask

    // Advance the model across the rising edge using the inputs held since the falling edge.
    task automatic step();
        wr_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            stv = 0; pend_v = 0; m_rsp_v = 0; m_rsp_a = '0; m_rsp_d = '0; just_reset = 1;
        end else begin
            just_reset = 0;
            m_rsp_v = pend_v;
            if (pend_v) begin
                m_rsp_a = pend_a;
                m_rsp_d = pend_d;
            end
            pend_v = e_ren;
            if (e_ren) begin
                pend_a = rd_addr;
                pend_d = ref_mem[rd_addr];
            end
            if (e_wen) begin
                ref_mem[q[0].a] = q[0].d;
                void'(q.pop_front());
                stv = 0;
            end else if ((q.size() > 0) && (stv < SMAX)) begin
                stv++;
            end
            if (wr_valid && e_wr_ready) begin
                e.a = wr_addr;
                e.d = wr_data;
                q.push_back(e);
            end
        end
    endtask

    task automatic cyc(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra);
        drive(r, wv, wa, wd, rv, ra);
        step();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int sub;
        sub = $urandom_range(0, 3);
        return AW'((sub << 7) | $urandom_range(0, 3));
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; wr_valid = 0; wr_addr = '0; wr_data = '0; rd_valid = 0; rd_addr = '0;
        stv = 0; pend_v = 0; m_rsp_v = 0; m_rsp_a = '0; m_rsp_d = '0; just_reset = 0;
        for (int i = 0; i < 2048; i++) begin
            mem[i] <= init_val(i);
            ref_mem[i] = init_val(i);
        end

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post_reset_level", 32'(wq_level), 0);
        chk("post_reset_rsp", 32'({rsp_valid, rsp_addr, rsp_data}), 0);
        step();

        // Write then read back.
        drive(0, 1, 11'h7FF, 8'hA5, 0, 0);
        chk("s1_wr_ready", 32'(wr_ready), 1);
        step();
        drive(0, 0, 0, 0, 1, 11'h7FF);
        chk("s1_stall", 32'(rd_ready), 0);
        chk("s1_drain", 32'(mem_wen), 1);
        step();
        drive(0, 0, 0, 0, 1, 11'h7FF);
        chk("s1_accept", 32'(rd_ready), 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("s1_rsp_early", 32'(rsp_valid), 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("s1_rsp_valid", 32'(rsp_valid), 1);
        chk("s1_rsp_addr", 32'(rsp_addr), 'h7FF);
        chk("s1_rsp_data", 32'(rsp_data), 'hA5);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("s1_rsp_once", 32'(rsp_valid), 0);
        step();

        // Queue full under continuous conflicting reads.
        for (int i = 0; i < 4; i++) cyc(0, 1, AW'(i), DW'('h40 + i), 1, 11'h010);
        drive(0, 1, 11'h004, 8'h44, 1, 11'h010);
        chk("s2_level_full", 32'(wq_level), 4);
        chk("s2_wr_held", 32'(wr_ready), 0);
        chk("s2_force_rd", 32'(rd_ready), 0);
        chk("s2_force_wen", 32'(mem_wen), 1);
        chk("s2_force_addr", 32'(mem_waddr), 0);
        step();
        drive(0, 1, 11'h004, 8'h44, 1, 11'h010);
        chk("s2_rd_back", 32'(rd_ready), 1);
        chk("s2_wr_back", 32'(wr_ready), 1);
        step();
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0);

        // Different sub-memories in the same cycle.
        cyc(0, 1, 11'h080, 8'h5A, 0, 0);
        drive(0, 0, 0, 0, 1, 11'h100);
        chk("s3_wen", 32'(mem_wen), 1);
        chk("s3_ren", 32'(mem_ren), 1);
        step();
        cyc(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("s3_rsp_addr", 32'(rsp_addr), 'h100);
        chk("s3_rsp_data", 32'(rsp_data), 'h3C);
        step();

        // Back-to-back reads.
        cyc(0, 0, 0, 0, 1, 11'h200);
        cyc(0, 0, 0, 0, 1, 11'h201);
        drive(0, 0, 0, 0, 1, 11'h202);
        chk("s4_rsp0", 32'({rsp_valid, rsp_data}), 'h111);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("s4_rsp1", 32'({rsp_valid, rsp_data}), 'h122);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("s4_rsp2", 32'({rsp_valid, rsp_data}), 'h133);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("s4_rsp_end", 32'(rsp_valid), 0);
        step();

        // Reset with queued writes and a read in flight.
        cyc(0, 1, 11'h400, 8'hE1, 1, 11'h410);
        cyc(0, 1, 11'h401, 8'hE2, 1, 11'h410);
        cyc(0, 1, 11'h402, 8'hE3, 1, 11'h410);
        drive(1, 0, 0, 0, 1, 11'h410);
        chk("s5_level_pre", 32'(wq_level), 3);
        step();
        drive(0, 0, 0, 0, 1, 11'h401);
        chk("s5_level_post", 32'(wq_level), 0);
        chk("s5_rsp_dropped", 32'(rsp_valid), 0);
        step();
        cyc(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("s5_old_addr", 32'(rsp_addr), 'h401);
        chk("s5_old_data", 32'(rsp_data), 'h3D);
        step();

        // Hazard against a non-head entry.
        cyc(0, 1, 11'h300, 8'h77, 1, 11'h370);
        cyc(0, 1, 11'h301, 8'h88, 1, 11'h370);
        drive(0, 0, 0, 0, 1, 11'h301);
        chk("s6_level", 32'(wq_level), 2);
        chk("s6_stall0", 32'(rd_ready), 0);
        step();
        drive(0, 0, 0, 0, 1, 11'h301);
        chk("s6_stall1", 32'(rd_ready), 0);
        step();
        drive(0, 0, 0, 0, 1, 11'h301);
        chk("s6_accept", 32'(rd_ready), 1);
        step();
        cyc(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("s6_rsp_addr", 32'(rsp_addr), 'h301);
        chk("s6_rsp_data", 32'(rsp_data), 'h88);
        step();

        // Randomized traffic over a few sub-memories to provoke conflicts and hazards.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0), 1'($urandom), rand_addr(), 8'($urandom),
                1'($urandom), rand_addr());
        end
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bank_access_ctrl.md
# bank_access_ctrl

Request-side controller for the 2048 x 8 multi-bank memory: accepts independent read and write requests from a client, queues writes, and issues at most one read and one write per cycle on the memory's `ren`/`wen`/`raddr`/`waddr`/`din`/`dout` port. It keeps the memory from losing a write when a read and a write target the same 128-entry sub-memory (the memory gives the read priority and drops the write). It also stalls reads that would bypass a queued write, and returns read data with a fixed latency. It sits between client logic and `Multi_Bank_Memory`.

## Interface
- `ADDR_W`, 11, address width; bits [ADDR_W-1:7] select the sub-memory.
- `DATA_W`, 8, data width.
- `WQ_DEPTH`, 4, write-queue entries (power of two).
- `STARVE_MAX`, 3, consecutive blocked cycles before the queued write is forced through.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_valid`  in  1  client write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready` at an edge.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `rd_valid`  in  1  client read request.
- `rd_ready`  out  1  read accepted when `rd_valid & rd_ready` at an edge.
- `rd_addr`  in  ADDR_W  read address.
- `rsp_valid`  out  1  one-cycle pulse; read data is valid.
- `rsp_addr`  out  ADDR_W  address of the returned read.
- `rsp_data`  out  DATA_W  returned read data.
- `wq_level`  out  $clog2(WQ_DEPTH)+1  number of queued writes.
- `mem_ren`  out  1  to memory `ren`.
- `mem_raddr`  out  ADDR_W  to memory `raddr`.
- `mem_wen`  out  1  to memory `wen`.
- `mem_waddr`  out  ADDR_W  to memory `waddr`.
- `mem_din`  out  DATA_W  to memory `din`.
- `mem_dout`  in  DATA_W  from memory `dout`; registered in the memory, valid the cycle after `ren` is sampled.

## Operation
**Write queue**
- FIFO of {addr, data}.
- `wr_ready = !rst & (wq_level != WQ_DEPTH)`.
- A push and a pop in the same cycle leave the level unchanged.
- A full queue never accepts a write, even if it pops in that cycle.

**Read issue (combinational)**
- `mem_ren = rd_valid & rd_ready`; `mem_raddr = rd_addr`.
- `rd_ready = !rst & !hazard & !force_w`.
- `hazard`: `rd_addr` equals the address of any valid queue entry. This is an exact match against all entries.

**Write issue (combinational)**
- Head entry drives `mem_waddr`/`mem_din` whenever the queue is non-empty; otherwise both are 0.
- `mem_wen = !rst & nonempty & !(mem_ren & (mem_raddr[ADDR_W-1:7] == head_addr[ADDR_W-1:7]))`.
- The queue pops on any edge where `mem_wen` = 1.
- Different sub-memories (including different banks) may be read and written in the same cycle.

**Starvation counter `stv`** (0..STARVE_MAX)
- Increments on each edge where the queue is non-empty and the head write was blocked by a read conflict.
- Clears on any edge where `mem_wen` = 1.
- `force_w = (stv == STARVE_MAX)`: `rd_ready` = 0, so the head write issues that cycle.

**Response**
- A read accepted at edge N is sampled by the memory at edge N.
- At edge N+1 the block registers `rsp_valid` = 1, `rsp_data = mem_dout`, and `rsp_addr` = captured `rd_addr`.
- `rsp_valid` = 0 at edges with no read accepted at the previous edge.
- Reads complete in order, one per cycle maximum. There is no backpressure on the response.

## Timing
- Read latency: `rsp_valid` is high in the cycle following edge N+1 for a read accepted at edge N. Throughput is 1 read per cycle.
- Write: accepted at edge N; earliest memory write at edge N+1 (head issue).
- Reset (`rst` sampled high at an edge), after that edge:
  - queue empty, `wq_level` = 0, `stv` = 0
  - `rsp_valid` = 0, `rsp_addr` = 0, `rsp_data` = 0
- While `rst` is high, `wr_ready` = `rd_ready` = `mem_ren` = `mem_wen` = 0.
- Reset mid-operation discards queued writes and drops the response to a read accepted at the reset edge.
- Same-cycle read and write to the same address is impossible: the hazard stall holds the read, so the write drains first.

## Test plan
- **Write then read back:** after reset, write 0x7FF←0xA5, then read 0x7FF.
  - `rd_ready` stays 0 until the queue drains.
  - `rsp_valid` pulses once, with `rsp_addr` = 0x7FF and `rsp_data` = 0xA5.
- **Queue full:** push 4 writes to 0x000–0x003 while continuously reading 0x010 (same sub-memory).
  - `wq_level` reaches 4 and `wr_ready` = 0.
  - The 5th write is held.
  - After 3 blocked cycles `rd_ready` drops for 1 cycle and one write issues.
- **No conflict:** write 0x080 and read 0x100 in the same cycle.
  - Both `mem_wen` and `mem_ren` = 1 that cycle.
  - Response returns the prior content of 0x100.
- **Back-to-back reads:** reads of 0x200, 0x201, 0x202 on consecutive edges, with the memory preloaded with 0x11, 0x22, 0x33.
  - Three consecutive `rsp_valid` pulses, in order, returning 0x11, 0x22, 0x33.
- **Reset mid-operation:** assert `rst` with 3 queued writes and one read in flight.
  - `wq_level` = 0 and `rsp_valid` = 0 next cycle.
  - A subsequent read of a discarded write address returns the old data.
- **Hazard across entries:** queue writes to 0x300 and 0x301, then request a read of 0x301.
  - The read stalls until both pop.
  - Returned data equals the second write's data.
